// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and opcode check for the ALU
// byte-stream sequencer.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  localparam logic [2:0] ST_GET_A  = 3'd0;
  localparam logic [2:0] ST_GET_B  = 3'd1;
  localparam logic [2:0] ST_GET_OP = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_SEND   = 3'd4;

  typedef enum logic [2:0] {
    GET_A  = ST_GET_A,
    GET_B  = ST_GET_B,
    GET_OP = ST_GET_OP,
    EXEC   = ST_EXEC,
    SEND   = ST_SEND
  } state_t;

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL:
        op_valid = 1'b1;
      default:
        op_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// Idle-byte timeout counter for the ALU sequencer; only built when
// ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_timeout #(
  parameter int NB_TMO = 20
) (
  input  logic clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [NB_TMO-1:0] count;

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + 1'b1;
    end
  end

  assign o_expired = &count;

endmodule

// File: rtl/alu_sequencer.sv
// Byte-stream front end for the shared ALU: A, B, opcode in; one result
// byte out. Optional idle timeout under ALU_SEQ_TIMEOUT_EN.
import alu_pkg::*;

module alu_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_AB   = 8,
  parameter int NB_OP   = 6,
  parameter int NB_TMO  = 20
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic [NB_AB-1:0]   o_a_data,
  output logic [NB_AB-1:0]   o_b_data,
  output logic [NB_OP-1:0]   o_operation,
  input  logic [NB_AB-1:0]   i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_error,
  output logic               o_busy
);

  state_t state;
  state_t state_nxt;

  logic rx_ready;
  logic load_a;
  logic load_b;
  logic load_op;
  logic tx_load;
  logic tx_done;
  logic err_nxt;
  logic tmo;
  logic [OP_W-1:0] op_byte;

  assign op_byte = OP_W'(i_rx_data[NB_OP-1:0]);

`ifdef ALU_SEQ_TIMEOUT_EN
  logic tmo_en;
  logic tmo_clr;

  // Counting only while waiting mid-transaction; SEND never times out.
  assign tmo_en  = (state == GET_B || state == GET_OP)
                   && !i_rx_valid;
  assign tmo_clr = i_rx_valid || state == GET_A;

  alu_seq_timeout #(
    .NB_TMO(NB_TMO)
  ) u_timeout (
    .clock    (clock),
    .i_reset_n(i_reset_n),
    .i_clear  (tmo_clr),
    .i_enable (tmo_en),
    .o_expired(tmo)
  );
`else
  logic unused_tmo;

  assign unused_tmo = ^NB_TMO;
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= GET_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    tx_load   = 1'b0;
    tx_done   = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      GET_A: begin
        rx_ready = 1'b1;
        if (i_rx_valid) begin
          load_a    = 1'b1;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        rx_ready = 1'b1;
        if (i_rx_valid) begin
          load_b    = 1'b1;
          state_nxt = GET_OP;
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = GET_A;
        end
      end
      GET_OP: begin
        rx_ready = 1'b1;
        if (i_rx_valid) begin
          if (op_valid(op_byte)) begin
            load_op   = 1'b1;
            state_nxt = EXEC;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = GET_A;
          end
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = GET_A;
        end
      end
      EXEC: begin
        tx_load   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          tx_done   = 1'b1;
          state_nxt = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_a_data    <= '0;
      o_b_data    <= '0;
      o_operation <= '0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_error <= err_nxt;
      if (load_a) begin
        o_a_data <= i_rx_data[NB_AB-1:0];
      end
      if (load_b) begin
        o_b_data <= i_rx_data[NB_AB-1:0];
      end
      if (load_op) begin
        o_operation <= i_rx_data[NB_OP-1:0];
      end
      // Operands are signed, so the result widens by sign extension.
      if (tx_load) begin
        o_tx_data  <= NB_DATA'($signed(i_alu_result));
        o_tx_valid <= 1'b1;
      end else if (tx_done) begin
        o_tx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_ready = rx_ready;
  assign o_busy     = (state != GET_A);

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Byte-stream front end that sequences the shared ALU: collects operand A, operand B and an opcode from a valid/ready byte source, such as a UART RX.
- Drives the ALU operand/opcode registers, waits one settle cycle, captures the combinational ALU result, then returns it as one byte on a valid/ready sink, such as a UART TX.
- Replaces button-based operand loading at the top level; the ALU itself stays unchanged.

Parameters:
- NB_DATA, 8, stream byte width.
- NB_AB, 8, ALU operand/result width; must be <= NB_DATA.
- NB_OP, 6, ALU opcode width; must be <= NB_DATA.
- NB_TMO, 20, timeout counter width; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_DATA  incoming byte.
- i_rx_valid  in  1  incoming byte valid.
- o_rx_ready  out  1  block accepts a byte this cycle.
- o_a_data  out  NB_AB  operand A to the ALU (registered).
- o_b_data  out  NB_AB  operand B to the ALU (registered).
- o_operation  out  NB_OP  opcode to the ALU (registered).
- i_alu_result  in  NB_AB  combinational ALU result.
- o_tx_data  out  NB_DATA  result byte.
- o_tx_valid  out  1  result byte valid.
- i_tx_ready  in  1  sink accepts the byte.
- o_error  out  1  one-cycle pulse on an unsupported opcode (or on a timeout).
- o_busy  out  1  high in every state except GET_A.

Behaviour:
- Reset: asserting i_reset_n low asynchronously clears all registers. Outputs at reset: o_a_data, o_b_data, o_operation, o_tx_data = 0; o_tx_valid = 0; o_error = 0; state = GET_A.
- Reset mid-transaction aborts it; no partial result is ever emitted.
- States: GET_A -> GET_B -> GET_OP -> EXEC -> SEND -> GET_A.
- GET_A / GET_B / GET_OP:
  - o_rx_ready = 1.
  - A transfer occurs when i_rx_valid && o_rx_ready.
  - On transfer, the low NB_AB (NB_OP for the opcode) bits of i_rx_data load the matching output register, and the FSM advances.
  - Upper bits of the byte are ignored.
- GET_OP with an opcode outside the package's valid list:
  - o_operation stays unchanged; o_error pulses for 1 cycle; next state is GET_A.
  - o_a_data and o_b_data keep their values.
- EXEC:
  - o_rx_ready = 0.
  - Lasts exactly 1 cycle to let the ALU settle.
  - At the end of that cycle, o_tx_data <= sign-extended i_alu_result (operands are signed) and o_tx_valid <= 1.
- SEND:
  - o_tx_valid held at 1 and o_tx_data stable until i_tx_ready = 1.
  - On the handshake cycle, o_tx_valid <= 0 and the next state is GET_A.
- Latency: last opcode byte accepted at cycle N -> o_tx_valid high at cycle N+2.
- o_rx_ready is 0 in EXEC and SEND; incoming bytes are backpressured, never dropped.
- o_a_data, o_b_data and o_operation hold their last values between transactions, so the ALU output stays meaningful.
- No combinational path from i_tx_ready or i_rx_valid to any output except the state-decoded o_rx_ready.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - An NB_TMO-bit counter increments each cycle while in GET_B or GET_OP without a transfer.
  - It clears on every transfer and on entering GET_A.
  - At all-ones: o_error pulses 1 cycle, the FSM returns to GET_A, and partial operands are kept but not executed.
  - SEND never times out.
- Not defined: no counter is instantiated, and the block waits indefinitely for the next byte.

Decomposition:
- Package alu_pkg holds:
  - the opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010;
  - the state encoding localparams;
  - the valid-opcode check function.
- Sub-module: alu_seq_timeout (counter plus terminal-count flag), instantiated only under the macro.
- The FSM, the operand registers and the TX register stay in alu_sequencer.

Test Plan:
- Basic add: send 0x05, 0x03, 0x20 with i_tx_ready=1 -> o_operation=0x20 and o_tx_data=0x08; o_tx_valid high exactly 2 cycles after the opcode transfer, for 1 cycle.
- Signed subtract: send 0x02, 0x05, 0x22 -> o_tx_data=0xFD.
- Backpressure: hold i_tx_ready=0 for 10 cycles during SEND -> o_tx_valid and o_tx_data stable, o_rx_ready=0 throughout, and the next byte is accepted only after the handshake.
- Invalid opcode: send 0x01, 0x01, 0x3F -> o_error pulses once, no o_tx_valid, state back to GET_A, o_operation unchanged.
- Reset mid-operation: drive i_reset_n low for 1 cycle after operand B is accepted -> all outputs 0 immediately (asynchronously); a following full transaction executes correctly.
- Timeout (macro defined, NB_TMO=4): send A only, then idle 15 cycles -> o_error pulses and the FSM returns to GET_A; with the macro undefined the FSM stays in GET_B.
